ambient_sensor_sampler: RTL and testbench

//  Front-end stage directly upstream of the ambient controller. Collects raw samples

---
 rtl/ambient_pkg.sv | 30 +++
 rtl/sensor_avg_channel.sv | 65 ++++++
 rtl/ambient_sensor_sampler.sv | 152 +++++++++++++++
 tb/tb_ambient_sensor_sampler.sv | 245 ++++++++++++++++++++++++
 4 files changed

// File: rtl/ambient_pkg.sv
// Shared constants and state encoding for the ambient sensor sampler.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package ambient_pkg;

  // Default geometry of the sensor front-end
  localparam int DEF_DATA_WIDTH = 6;
  localparam int DEF_AVG_LOG2   = 2;

  // Clamp limits for the physically bounded channels
  localparam int DEF_HUM_MAX = 100;
  localparam int DEF_LUM_MAX = 1000;

  // Channel widths derived from the temperature width
  function automatic int hum_width(input int dw);
    return dw + 1;
  endfunction

  function automatic int lum_width(input int dw);
    return dw + 4;
  endfunction

  // Sampler control states
  typedef enum logic [1:0] {
    ST_OFF  = 2'd0,
    ST_ACQ  = 2'd1,
    ST_HOLD = 2'd2
  } state_e;

endpackage

// File: rtl/sensor_avg_channel.sv
// One sensor channel: optional clamp, block accumulator, sample counter, done flag.
// Latency: done_o rises on the edge that captures the last sample of a block.
// Backpressure: strobes arriving while done_o is high are ignored until clear_i.
module sensor_avg_channel #(
  parameter int W        = 6,
  parameter int AVG_LOG2 = 2,
  parameter int MAX      = 0,
  parameter bit CLAMP_EN = 1'b0
) (
  input  logic         clk_i,
  input  logic         reset_i,
  input  logic         clear_i,
  input  logic         stb_i,
  input  logic [W-1:0] raw_i,
  output logic         done_o,
  output logic [W-1:0] avg_o
);

  localparam int AW = W + AVG_LOG2;
  localparam int CW = AVG_LOG2 + 1;
  localparam logic [W-1:0]  MAX_W = W'(MAX);
  localparam logic [CW-1:0] N     = CW'(2 ** AVG_LOG2);

  logic [AW-1:0] acc_q, acc_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          done_q, done_d;
  logic [W-1:0]  sample;
  logic [CW-1:0] cnt_inc;

  // Clamp, accumulate and count; clear wins over a same-cycle strobe
  always_comb begin
    sample  = (CLAMP_EN && (raw_i > MAX_W)) ? MAX_W : raw_i;
    cnt_inc = cnt_q + CW'(1);
    acc_d   = acc_q;
    cnt_d   = cnt_q;
    done_d  = done_q;
    if (clear_i) begin
      acc_d  = '0;
      cnt_d  = '0;
      done_d = 1'b0;
    end else if (stb_i && !done_q) begin
      acc_d  = acc_q + {{AVG_LOG2{1'b0}}, sample};
      cnt_d  = cnt_inc;
      done_d = (cnt_inc == N);
    end
  end

  // Channel state registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      acc_q  <= '0;
      cnt_q  <= '0;
      done_q <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      cnt_q  <= cnt_d;
      done_q <= done_d;
    end
  end

  assign done_o = done_q;
  // Truncating average: drop the low AVG_LOG2 bits of the block sum
  assign avg_o  = acc_q[AW-1:AVG_LOG2];

endmodule

// File: rtl/ambient_sensor_sampler.sv
// Averages temperature/humidity/luminous samples into frames for the ambient controller.
// Latency: frame presented one edge after the last channel completes its block.
// Backpressure: frame held until valid_o & ready_i; a frame completing meanwhile is dropped and flags overrun_o.
module ambient_sensor_sampler
  import ambient_pkg::*;
#(
  parameter int DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int AVG_LOG2   = DEF_AVG_LOG2,
  parameter int HUM_MAX    = DEF_HUM_MAX,
  parameter int LUM_MAX    = DEF_LUM_MAX
) (
  input  logic                  clk_i,
  input  logic                  reset_i,
  input  logic                  enable_i,
  input  logic [DATA_WIDTH-1:0] temp_raw_i,
  input  logic                  temp_stb_i,
  input  logic [DATA_WIDTH:0]   hum_raw_i,
  input  logic                  hum_stb_i,
  input  logic [DATA_WIDTH+3:0] lum_raw_i,
  input  logic                  lum_stb_i,
  output logic [DATA_WIDTH-1:0] temperature_o,
  output logic [DATA_WIDTH:0]   humidity_o,
  output logic [DATA_WIDTH+3:0] luminous_intensity_o,
  output logic                  valid_o,
  input  logic                  ready_i,
  output logic                  overrun_o
);

  localparam int TW = DATA_WIDTH;
  localparam int HW = hum_width(DATA_WIDTH);
  localparam int LW = lum_width(DATA_WIDTH);

  state_e        state_q, state_d;
  logic [TW-1:0] temp_q, temp_d;
  logic [HW-1:0] hum_q, hum_d;
  logic [LW-1:0] lum_q, lum_d;
  logic          valid_q, valid_d;
  logic          overrun_q, overrun_d;

  logic          chan_clear;
  logic          t_done, h_done, l_done;
  logic [TW-1:0] t_avg;
  logic [HW-1:0] h_avg;
  logic [LW-1:0] l_avg;
  logic          all_done;
  logic          xfer;

  assign all_done = t_done & h_done & l_done;
  assign xfer     = valid_q & ready_i;

  sensor_avg_channel #(
    .W(TW), .AVG_LOG2(AVG_LOG2), .MAX(0), .CLAMP_EN(1'b0)
  ) u_temp (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(chan_clear),
    .stb_i(temp_stb_i), .raw_i(temp_raw_i), .done_o(t_done), .avg_o(t_avg)
  );

  sensor_avg_channel #(
    .W(HW), .AVG_LOG2(AVG_LOG2), .MAX(HUM_MAX), .CLAMP_EN(1'b1)
  ) u_hum (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(chan_clear),
    .stb_i(hum_stb_i), .raw_i(hum_raw_i), .done_o(h_done), .avg_o(h_avg)
  );

  sensor_avg_channel #(
    .W(LW), .AVG_LOG2(AVG_LOG2), .MAX(LUM_MAX), .CLAMP_EN(1'b1)
  ) u_lum (
    .clk_i(clk_i), .reset_i(reset_i), .clear_i(chan_clear),
    .stb_i(lum_stb_i), .raw_i(lum_raw_i), .done_o(l_done), .avg_o(l_avg)
  );

  // State and output-frame registers
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= ST_OFF;
      temp_q    <= '0;
      hum_q     <= '0;
      lum_q     <= '0;
      valid_q   <= 1'b0;
      overrun_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      temp_q    <= temp_d;
      hum_q     <= hum_d;
      lum_q     <= lum_d;
      valid_q   <= valid_d;
      overrun_q <= overrun_d;
    end
  end

  // Next-state: disable forces OFF from anywhere
  always_comb begin
    state_d = state_q;
    if (!enable_i) begin
      state_d = ST_OFF;
    end else begin
      case (state_q)
        ST_OFF:  state_d = ST_ACQ;
        ST_ACQ:  if (all_done) state_d = ST_HOLD;
        ST_HOLD: if (xfer) state_d = ST_ACQ;
        default: state_d = ST_OFF;
      endcase
    end
  end

  // Frame launch, transfer, overrun drop and channel clearing
  always_comb begin
    temp_d     = temp_q;
    hum_d      = hum_q;
    lum_d      = lum_q;
    valid_d    = valid_q;
    overrun_d  = overrun_q;
    chan_clear = 1'b0;
    if (!enable_i) begin
      temp_d     = '0;
      hum_d      = '0;
      lum_d      = '0;
      valid_d    = 1'b0;
      overrun_d  = 1'b0;
      chan_clear = 1'b1;
    end else begin
      case (state_q)
        ST_ACQ: begin
          if (all_done) begin
            temp_d     = t_avg;
            hum_d      = h_avg;
            lum_d      = l_avg;
            valid_d    = 1'b1;
            chan_clear = 1'b1;
          end
        end
        ST_HOLD: begin
          // A frame completing on the transfer edge is kept and launched from ACQ next edge
          if (xfer) begin
            valid_d = 1'b0;
          end else if (all_done) begin
            overrun_d  = 1'b1;
            chan_clear = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  assign temperature_o        = temp_q;
  assign humidity_o           = hum_q;
  assign luminous_intensity_o = lum_q;
  assign valid_o              = valid_q;
  assign overrun_o            = overrun_q;

endmodule

// File: tb/tb_ambient_sensor_sampler.sv
// Directed bench for ambient_sensor_sampler with an expected-frame scoreboard.
// Inputs change 1ns after rising edges; outputs are sampled on falling edges or 1ns after rising edges.
// Frames are compared when the bench observes valid_o & ready_i (a transfer on the next edge).
module tb_ambient_sensor_sampler;

  logic       clk_i;
  logic       reset_i;
  logic       enable_i;
  logic [5:0] temp_raw_i;
  logic       temp_stb_i;
  logic [6:0] hum_raw_i;
  logic       hum_stb_i;
  logic [9:0] lum_raw_i;
  logic       lum_stb_i;
  logic [5:0] temperature_o;
  logic [6:0] humidity_o;
  logic [9:0] luminous_intensity_o;
  logic       valid_o;
  logic       ready_i;
  logic       overrun_o;

  ambient_sensor_sampler dut (
    .clk_i(clk_i), .reset_i(reset_i), .enable_i(enable_i),
    .temp_raw_i(temp_raw_i), .temp_stb_i(temp_stb_i),
    .hum_raw_i(hum_raw_i), .hum_stb_i(hum_stb_i),
    .lum_raw_i(lum_raw_i), .lum_stb_i(lum_stb_i),
    .temperature_o(temperature_o), .humidity_o(humidity_o),
    .luminous_intensity_o(luminous_intensity_o),
    .valid_o(valid_o), .ready_i(ready_i), .overrun_o(overrun_o)
  );

  initial clk_i = 1'b0;
  always #5 clk_i = ~clk_i;

  typedef struct {
    int t;
    int h;
    int l;
  } frame_t;

  frame_t exp_q[$];
  int     vectors;
  int     miscompares;
  int     valid_cycles;
  int     v0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic push_exp(input int t, input int h, input int l);
    frame_t f;
    f.t = t;
    f.h = h;
    f.l = l;
    exp_q.push_back(f);
  endtask

  // Falling-edge observation: count valid cycles, score frames about to transfer
  task automatic monitor();
    frame_t f;
    if (valid_o) valid_cycles++;
    if (valid_o && ready_i) begin
      check("frame_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) begin
        f = exp_q.pop_front();
        check("frame_temp", 32'(temperature_o), 32'(f.t));
        check("frame_hum", 32'(humidity_o), 32'(f.h));
        check("frame_lum", 32'(luminous_intensity_o), 32'(f.l));
      end
    end
  endtask

  // Advance one cycle: from rising+1ns through falling edge to next rising+1ns
  task automatic tick();
    @(negedge clk_i);
    monitor();
    @(posedge clk_i);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) tick();
  endtask

  task automatic strobe_all(input int t, input int h, input int l);
    temp_raw_i = 6'(t);
    hum_raw_i  = 7'(h);
    lum_raw_i  = 10'(l);
    temp_stb_i = 1'b1;
    hum_stb_i  = 1'b1;
    lum_stb_i  = 1'b1;
    tick();
    temp_stb_i = 1'b0;
    hum_stb_i  = 1'b0;
    lum_stb_i  = 1'b0;
  endtask

  task automatic strobe_temp(input int t);
    temp_raw_i = 6'(t);
    temp_stb_i = 1'b1;
    tick();
    temp_stb_i = 1'b0;
  endtask

  task automatic wait_valid(input string tag, input int max_cycles);
    for (int i = 0; i < max_cycles && !valid_o; i++) tick();
    check(tag, 32'(valid_o), 32'd1);
  endtask

  initial begin
    vectors      = 0;
    miscompares  = 0;
    valid_cycles = 0;
    reset_i      = 1'b1;
    enable_i     = 1'b0;
    ready_i      = 1'b1;
    temp_raw_i   = '0;
    temp_stb_i   = 1'b0;
    hum_raw_i    = '0;
    hum_stb_i    = 1'b0;
    lum_raw_i    = '0;
    lum_stb_i    = 1'b0;
    repeat (2) @(posedge clk_i);
    #1;

    // Reset state
    check("rst_valid", 32'(valid_o), 32'd0);
    check("rst_temp", 32'(temperature_o), 32'd0);
    check("rst_hum", 32'(humidity_o), 32'd0);
    check("rst_lum", 32'(luminous_intensity_o), 32'd0);
    check("rst_overrun", 32'(overrun_o), 32'd0);

    reset_i  = 1'b0;
    enable_i = 1'b1;
    idle(1);

    // 1: plain averaging, consumer always ready, valid for exactly one cycle
    v0 = valid_cycles;
    push_exp(23, 40, 500);
    strobe_all(20, 40, 500);
    strobe_all(22, 40, 500);
    strobe_all(24, 40, 500);
    strobe_all(26, 40, 500);
    idle(6);
    check("t1_valid_cycles", 32'(valid_cycles - v0), 32'd1);

    // 2: clamping of humidity and luminous intensity, temperature unclamped
    v0 = valid_cycles;
    push_exp(10, 100, 1000);
    repeat (4) strobe_all(10, 120, 1023);
    idle(6);
    check("t2_valid_cycles", 32'(valid_cycles - v0), 32'd1);

    // 3: frame held stable while consumer stalls for 50 cycles
    ready_i = 1'b0;
    push_exp(5, 50, 200);
    repeat (4) strobe_all(5, 50, 200);
    wait_valid("t3_valid_up", 10);
    repeat (50) begin
      tick();
      check("t3_hold_valid", 32'(valid_o), 32'd1);
      check("t3_hold_temp", 32'(temperature_o), 32'(exp_q[0].t));
      check("t3_hold_hum", 32'(humidity_o), 32'(exp_q[0].h));
      check("t3_hold_lum", 32'(luminous_intensity_o), 32'(exp_q[0].l));
    end
    ready_i = 1'b1;
    tick();
    check("t3_valid_after_xfer", 32'(valid_o), 32'd0);
    idle(2);

    // 4: two frames complete during a stall and are dropped
    ready_i = 1'b0;
    push_exp(1, 2, 3);
    repeat (4) strobe_all(1, 2, 3);
    idle(2);
    check("t4_first_valid", 32'(valid_o), 32'd1);
    check("t4_no_overrun_yet", 32'(overrun_o), 32'd0);
    repeat (4) strobe_all(7, 8, 9);
    idle(2);
    repeat (4) strobe_all(11, 12, 13);
    idle(2);
    check("t4_overrun", 32'(overrun_o), 32'd1);
    check("t4_hold_temp", 32'(temperature_o), 32'(exp_q[0].t));
    check("t4_hold_hum", 32'(humidity_o), 32'(exp_q[0].h));
    check("t4_hold_lum", 32'(luminous_intensity_o), 32'(exp_q[0].l));
    v0 = valid_cycles;
    ready_i = 1'b1;
    idle(8);
    check("t4_valid_cycles", 32'(valid_cycles - v0), 32'd1);
    check("t4_overrun_sticky", 32'(overrun_o), 32'd1);

    // 5: partial block discarded by disable
    strobe_temp(33);
    strobe_temp(33);
    enable_i = 1'b0;
    idle(1);
    check("t5_overrun_cleared", 32'(overrun_o), 32'd0);
    check("t5_valid_off", 32'(valid_o), 32'd0);
    idle(1);
    enable_i = 1'b1;
    idle(1);
    v0 = valid_cycles;
    push_exp(12, 60, 700);
    repeat (4) strobe_all(12, 60, 700);
    idle(6);
    check("t5_valid_cycles", 32'(valid_cycles - v0), 32'd1);

    // 6: asynchronous reset in the middle of a held frame
    ready_i = 1'b0;
    push_exp(20, 30, 40);
    repeat (4) strobe_all(20, 30, 40);
    idle(2);
    repeat (4) strobe_all(1, 1, 1);
    idle(2);
    check("t6_pre_valid", 32'(valid_o), 32'd1);
    check("t6_pre_overrun", 32'(overrun_o), 32'd1);
    check("t6_pre_temp", 32'(temperature_o), 32'(exp_q[0].t));
    #3;
    reset_i = 1'b1;
    #1;
    check("t6_rst_valid", 32'(valid_o), 32'd0);
    check("t6_rst_temp", 32'(temperature_o), 32'd0);
    check("t6_rst_hum", 32'(humidity_o), 32'd0);
    check("t6_rst_lum", 32'(luminous_intensity_o), 32'd0);
    check("t6_rst_overrun", 32'(overrun_o), 32'd0);
    void'(exp_q.pop_front());
    #2;
    reset_i = 1'b0;
    @(posedge clk_i);
    #1;
    idle(3);
    check("t6_valid_after_reset", 32'(valid_o), 32'd0);

    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
